// File: rtl/get_ins_stream_if.sv
// rtl/get_ins_stream_if.sv - FIFO-side and downstream-side stream signals of get_ins_stream
interface get_ins_stream_if #(
  parameter int DW = 64
);
  logic [DW-1:0] fifo_data_din;
  logic          fifo_last_din;
  logic          fifo_empty_n_din;
  logic          fifo_read_dout;
  logic [DW-1:0] data_dout;
  logic          data_valid_dout;
  logic          data_last_dout;
  logic          data_ready_din;

  modport master (
    input  fifo_data_din, fifo_last_din, fifo_empty_n_din, data_ready_din,
    output fifo_read_dout, data_dout, data_valid_dout, data_last_dout
  );

  modport slave (
    output fifo_data_din, fifo_last_din, fifo_empty_n_din, data_ready_din,
    input  fifo_read_dout, data_dout, data_valid_dout, data_last_dout
  );
endinterface

// File: rtl/get_ins_stream.sv
// rtl/get_ins_stream.sv - header-driven instruction/data splitter; GI_LAST_CHECK_EN enables TLAST checking
module get_ins_stream #(
  parameter int          DW        = 64,
  parameter int          INS_WORDS = 3,
  parameter int          HEAD_REP  = 2,
  parameter int          LEN_W     = 16,
  parameter logic [63:0] INST_HEAD = 64'hefef123abbeeff22,
  parameter logic [63:0] DATA_HEAD = 64'hefef6543dadaff11
) (
  input  logic                    clk,
  input  logic                    reset,
  get_ins_stream_if.master        bus,
  output logic [INS_WORDS*DW-1:0] ins_code_dout,
  output logic                    ins_valid_dout,
  output logic                    start_reg,
  output logic                    datald_done_dout,
  output logic [7:0]              hdr_err_cnt_dout,
  output logic                    last_err_dout,
  output logic                    busy_dout
);

  typedef enum logic [2:0] {S_HUNT, S_INST, S_INST_END, S_DLEN, S_DATA, S_DATA_END} state_t;

  localparam logic [DW-1:0] IHEAD = INST_HEAD[DW-1:0];
  localparam logic [DW-1:0] DHEAD = DATA_HEAD[DW-1:0];
`ifdef GI_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [DW-1:0]    word;
  logic             rd, pop, hs;
  logic             is_ihead, is_dhead, hdr_done;
  logic [2:0]       match_cnt, run_cnt;
  logic             cand_data;
  logic [3:0]       ins_cnt;
  logic [LEN_W-1:0] beat_cnt, len;
  logic             final_beat, tl_early, tl_mis;
  logic [DW-1:0]    data_q;
  logic             valid_q, last_q, last_err_q;

  assign word       = bus.fifo_data_din;
  assign len        = word[LEN_W-1:0];
  assign hs         = valid_q && bus.data_ready_din;
  assign final_beat = (beat_cnt == LEN_W'(1));
  assign tl_early   = LAST_CHECK && bus.fifo_last_din && !final_beat;
  assign tl_mis     = LAST_CHECK && (bus.fifo_last_din != final_beat);

  // A data header is only recognised if it is not also the instruction header.
  assign is_ihead = (word == IHEAD);
  assign is_dhead = (word == DHEAD) && !is_ihead;
  assign run_cnt  = (is_dhead == cand_data) ? match_cnt + 3'd1 : 3'd1;
  assign hdr_done = pop && (is_ihead || is_dhead) && (run_cnt == 3'(HEAD_REP));

  // Pop strobe is forced low during reset so nothing is consumed while held.
  always_comb begin
    rd = 1'b0;
    case (state)
      S_HUNT, S_INST, S_DLEN: rd = bus.fifo_empty_n_din;
      S_DATA: rd = bus.fifo_empty_n_din && (beat_cnt != '0) && (!valid_q || bus.data_ready_din);
      default: rd = 1'b0;
    endcase
    rd = rd && reset;
  end
  assign pop = rd;

  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT:     if (hdr_done) state_nxt = is_dhead ? S_DLEN : S_INST;
      S_INST:     if (pop && ins_cnt == 4'(INS_WORDS - 1)) state_nxt = S_INST_END;
      S_INST_END: state_nxt = S_HUNT;
      S_DLEN:     if (pop) state_nxt = (len == '0) ? S_DATA_END : S_DATA;
      S_DATA:     if (hs && last_q) state_nxt = S_DATA_END;
      S_DATA_END: state_nxt = S_HUNT;
      default:    state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HUNT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt        <= '0;
      cand_data        <= 1'b0;
      ins_cnt          <= '0;
      ins_code_dout    <= '0;
      start_reg        <= 1'b0;
      hdr_err_cnt_dout <= '0;
      beat_cnt         <= '0;
      data_q           <= '0;
      valid_q          <= 1'b0;
      last_q           <= 1'b0;
      last_err_q       <= 1'b0;
    end else begin
      case (state)
        S_HUNT: if (pop) begin
          if (is_ihead || is_dhead) begin
            cand_data <= is_dhead;
            match_cnt <= hdr_done ? 3'd0 : run_cnt;
          end else begin
            match_cnt <= '0;
            if (hdr_err_cnt_dout != 8'hff) hdr_err_cnt_dout <= hdr_err_cnt_dout + 8'd1;
          end
        end
        S_INST: if (pop) begin
          for (int k = 0; k < INS_WORDS; k++)
            if (ins_cnt == 4'(k)) ins_code_dout[k*DW +: DW] <= word;
          ins_cnt <= ins_cnt + 4'd1;
        end
        S_INST_END: begin
          start_reg <= ins_code_dout[DW-1];
          ins_cnt   <= '0;
        end
        S_DLEN: if (pop) beat_cnt <= len;
        S_DATA: begin
          if (pop) begin
            data_q   <= word;
            valid_q  <= 1'b1;
            last_q   <= final_beat || tl_early;
            // Early TLAST truncates the burst: no further pops.
            beat_cnt <= tl_early ? '0 : beat_cnt - LEN_W'(1);
            if (tl_mis) last_err_q <= 1'b1;
          end else if (hs) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_read_dout  = rd;
  assign bus.data_dout       = data_q;
  assign bus.data_valid_dout = valid_q;
  assign bus.data_last_dout  = last_q;
  assign ins_valid_dout      = (state == S_INST_END);
  assign datald_done_dout    = (state == S_DATA_END);
  assign busy_dout           = (state != S_HUNT);
  assign last_err_dout       = last_err_q;

endmodule
